// File: rtl/div_pipe_rv_if.sv
// Handshake/data bundle for the pipelined divider div_pipe_rv.
// The flush signal exists only when DIV_FLUSH_EN is defined.
interface div_pipe_rv_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 5
);
    logic                  in_valid;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  stall;
`ifdef DIV_FLUSH_EN
    logic                  flush;
`endif
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] result;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic                  busy;

`ifdef DIV_FLUSH_EN
    modport master (
        output in_valid, op, dividend, divisor, in_tag, stall, flush,
        input  out_valid, result, out_tag, busy
    );
    modport slave (
        input  in_valid, op, dividend, divisor, in_tag, stall, flush,
        output out_valid, result, out_tag, busy
    );
`else
    modport master (
        output in_valid, op, dividend, divisor, in_tag, stall,
        input  out_valid, result, out_tag, busy
    );
    modport slave (
        input  in_valid, op, dividend, divisor, in_tag, stall,
        output out_valid, result, out_tag, busy
    );
`endif
endinterface

// File: rtl/div_pipe_rv.sv
// Fully pipelined non-restoring divider (DIV/DIVU/REM/REMU) with pass-through tag.
// Define DIV_FLUSH_EN to add a flush input that kills all in-flight ops.
module div_pipe_rv #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BITS_PER_STAGE = 1,
    parameter int unsigned TAG_WIDTH      = 5
) (
    input logic           clk,
    input logic           rst_n,
    div_pipe_rv_if.slave  bus
);
    localparam int unsigned W       = DATA_WIDTH;
    localparam int unsigned NumIter = DATA_WIDTH / BITS_PER_STAGE;
    localparam logic [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};

    typedef struct packed {
        logic                 valid;
        logic                 sel_rem;
        logic [TAG_WIDTH-1:0] tag;
        logic                 qsign;
        logic                 rsign;
        logic                 dz;
        logic                 ovf;
        logic [W-1:0]         dvsr;
        logic [W:0]           rem;
        logic [W-1:0]         quo;
    } stage_t;

    stage_t         stg_q [NumIter+1];
    stage_t         stg_d [NumIter+1];
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   result_q, result_d;
    logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
    logic           signed_op, a_neg, d_neg, busy_c;

    function automatic stage_t nr_step(input stage_t s);
        stage_t     t;
        logic [W:0] sh;
        t  = s;
        sh = {s.rem[W-1:0], s.quo[W-1]};
        sh = s.rem[W] ? sh + {1'b0, s.dvsr} : sh - {1'b0, s.dvsr};
        t.rem = sh;
        t.quo = {s.quo[W-2:0], ~sh[W]};
        return t;
    endfunction

    // With a zero divisor the iterations leave rem = |dividend| and quo = all ones,
    // so REM/REMU by zero falls out of the normal sign-correction path.
    function automatic logic [W-1:0] finish(input stage_t s);
        logic [W-1:0] r, q, rm;
        r  = s.rem[W-1:0] + (s.rem[W] ? s.dvsr : '0);
        q  = s.qsign ? -s.quo : s.quo;
        rm = s.rsign ? -r : r;
        if (s.ovf)     return s.sel_rem ? '0 : MinVal;
        else if (s.dz) return s.sel_rem ? rm : '1;
        else           return s.sel_rem ? rm : q;
    endfunction

    always_comb begin
        for (int i = 0; i <= NumIter; i++) stg_d[i] = stg_q[i];
        out_valid_d = out_valid_q;
        result_d    = result_q;
        out_tag_d   = out_tag_q;
        signed_op   = ~bus.op[0];
        a_neg       = signed_op & bus.dividend[W-1];
        d_neg       = signed_op & bus.divisor[W-1];

        if (!bus.stall) begin
            stg_d[0].valid   = bus.in_valid;
            stg_d[0].sel_rem = bus.op[1];
            stg_d[0].tag     = bus.in_tag;
            stg_d[0].qsign   = a_neg ^ d_neg;
            stg_d[0].rsign   = a_neg;
            stg_d[0].dz      = (bus.divisor == '0);
            stg_d[0].ovf     = signed_op && (bus.dividend == MinVal) && (&bus.divisor);
            stg_d[0].dvsr    = d_neg ? -bus.divisor : bus.divisor;
            stg_d[0].rem     = '0;
            stg_d[0].quo     = a_neg ? -bus.dividend : bus.dividend;

            for (int s = 1; s <= NumIter; s++) begin
                stg_d[s] = stg_q[s-1];
                for (int b = 0; b < BITS_PER_STAGE; b++) stg_d[s] = nr_step(stg_d[s]);
            end

            out_valid_d = stg_q[NumIter].valid;
            result_d    = stg_q[NumIter].valid ? finish(stg_q[NumIter]) : '0;
            out_tag_d   = stg_q[NumIter].valid ? stg_q[NumIter].tag : '0;
        end

`ifdef DIV_FLUSH_EN
        if (bus.flush) begin
            for (int i = 0; i <= NumIter; i++) stg_d[i].valid = 1'b0;
            out_valid_d = 1'b0;
            result_d    = '0;
            out_tag_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NumIter; i++) stg_q[i] <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            out_tag_q   <= '0;
        end else begin
            for (int i = 0; i <= NumIter; i++) stg_q[i] <= stg_d[i];
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            out_tag_q   <= out_tag_d;
        end
    end

    always_comb begin
        busy_c = out_valid_q;
        for (int i = 0; i <= NumIter; i++) busy_c = busy_c | stg_q[i].valid;
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.busy      = busy_c;
endmodule

// File: tb/tb_div_pipe_rv.sv
// Self-checking bench for div_pipe_rv: directed corner cases, random ops with stall
// bursts against an arithmetic reference model, mid-flight reset and (DIV_FLUSH_EN) flush.
module tb_div_pipe_rv;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 5;
`ifdef DIV_FLUSH_EN
    localparam int unsigned BPS = 2;
`else
    localparam int unsigned BPS = 1;
`endif
    localparam int unsigned LAT  = DW / BPS + 2;
    localparam logic [31:0] MINV = 32'h8000_0000;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];

    div_pipe_rv_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    div_pipe_rv #(
        .DATA_WIDTH    (DW),
        .BITS_PER_STAGE(BPS),
        .TAG_WIDTH     (TW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Division semantics straight from the operation definitions.
    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
                return sa / sb;
            end
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return MINV;
            4:       return 32'($urandom_range(0, 20));
            5:       return -32'($urandom_range(1, 20));
            default: return $urandom();
        endcase
    endfunction

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_tag   = tag;
    endtask

    task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag,
                           input logic [31:0] exp);
        int lat;
        drive(op, a, b, tag);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < int'(LAT) + 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_lat"}, lat, LAT);
        check({name, "_res"}, bus.result, exp);
        check({name, "_tag"}, bus.out_tag, tag);
        @(posedge clk);
        #1;
        check({name, "_once"}, bus.out_valid, 1'b0);
    endtask

    task automatic watch_quiet(input string name);
        int seen = 0;
        repeat (LAT + 5) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check(name, seen, 0);
    endtask

    // Output side of the random phase: an output is consumed at the first edge without stall.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    check("rand_res", bus.result, exp_q[0].res);
                    check("rand_tag", bus.out_tag, exp_q[0].tag);
                    if (!bus.stall) void'(exp_q.pop_front());
                end
            end else begin
                check("idle_zero", {bus.result, bus.out_tag}, '0);
            end
        end
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          issued;
        int          burst;

        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.op       = 2'b00;
        bus.dividend = '0;
        bus.divisor  = '0;
        bus.in_tag   = '0;
        bus.stall    = 1'b0;
`ifdef DIV_FLUSH_EN
        bus.flush    = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_result", bus.result, '0);
        check("rst_tag", bus.out_tag, '0);
        check("rst_busy", bus.busy, 1'b0);
        #10 rst_n = 1'b1;

        run_one("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd3, 32'd14);
        run_one("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd4, 32'd2);
        run_one("div_m7_2", 2'b00, -32'd7, 32'd2, 5'd5, 32'hFFFF_FFFD);
        run_one("rem_m7_2", 2'b10, -32'd7, 32'd2, 5'd6, 32'hFFFF_FFFF);
        run_one("rem_7_m2", 2'b10, 32'd7, -32'd2, 5'd7, 32'd1);
        run_one("div_5_0", 2'b00, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF);
        run_one("remu_5_0", 2'b11, 32'd5, 32'd0, 5'd9, 32'd5);
        run_one("rem_m5_0", 2'b10, -32'd5, 32'd0, 5'd10, 32'hFFFF_FFFB);
        run_one("div_ovf", 2'b00, MINV, 32'hFFFF_FFFF, 5'd11, MINV);
        run_one("rem_ovf", 2'b10, MINV, 32'hFFFF_FFFF, 5'd12, 32'd0);
        run_one("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd13, 32'hFFFF_FFFF);

        // Random back-to-back ops with stall bursts; in_valid is toggled during stall too.
        mon_en = 1'b1;
        issued = 0;
        burst  = 0;
        while (issued < 300) begin
            if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 6);
            bus.stall = (burst > 0);
            if (burst > 0) burst--;
            rop = 2'($urandom_range(0, 3));
            ra  = rand_operand();
            rb  = rand_operand();
            drive(rop, ra, rb, 5'(issued));
            if (bus.stall) begin
                bus.in_valid = 1'($urandom_range(0, 1));
            end else begin
                exp_q.push_back('{res: ref_model(rop, ra, rb), tag: 5'(issued)});
                issued++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.stall    = 1'b0;
        for (int c = 0; c < 4 * int'(LAT) && exp_q.size() > 0; c++) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
        mon_en = 1'b0;

        // Reset with ops in flight.
        for (int i = 0; i < 10; i++) begin
            drive(2'b01, 32'd1000 + 32'(i), 32'd3, 5'(i));
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_valid", bus.out_valid, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        watch_quiet("midrst_no_out");
        run_one("post_rst_divu", 2'b01, 32'd100, 32'd7, 5'd3, 32'd14);

`ifdef DIV_FLUSH_EN
        for (int i = 0; i < 5; i++) begin
            drive(2'b00, -32'd50 - 32'(i), 32'd4, 5'(20 + i));
            @(posedge clk);
            #1;
        end
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_busy", bus.busy, 1'b0);
        check("flush_valid", bus.out_valid, 1'b0);
        bus.flush    = 1'b0;
        bus.stall    = 1'b0;
        bus.in_valid = 1'b0;
        watch_quiet("flush_no_out");
        run_one("post_flush_divu", 2'b01, 32'd100, 32'd7, 5'd3, 32'd14);
        run_one("post_flush_remu", 2'b11, 32'd100, 32'd7, 5'd3, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/div_pipe_rv.md
DIV_PIPE_RV -- requirements
Module: div_pipe_rv

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, as the operand/result width in bits.
REQ-002 The block SHALL take parameter BITS_PER_STAGE, default 1, as the quotient bits resolved per pipeline stage; legal values divide DATA_WIDTH (1, 2, 4).
REQ-003 The block SHALL take parameter TAG_WIDTH, default 5, as the width of the pass-through tag.
REQ-004 clk  input  1  clock; rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation present this cycle.
REQ-006 op  input  2  00=DIV signed quotient, 01=DIVU, 10=REM signed remainder, 11=REMU.
REQ-007 dividend, divisor  input  DATA_WIDTH each  operands.
REQ-008 in_tag  input  TAG_WIDTH  opaque tag (e.g. rd index) carried with the op.
REQ-009 stall  input  1  freezes every pipeline stage, valids included.
REQ-010 flush  input  1  kills all in-flight ops; present only under DIV_FLUSH_EN.
REQ-011 out_valid  output  1; result  output  DATA_WIDTH; out_tag  output  TAG_WIDTH; busy  output  1  (OR of all stage valids).

Function
REQ-012 The block SHALL be fully pipelined and accept one op per non-stalled cycle; there is no input backpressure other than stall.
REQ-013 The latency SHALL be LAT = DATA_WIDTH/BITS_PER_STAGE + 2 clk edges from the sampling edge of in_valid to out_valid, with no stall.
REQ-014 Stage 0 SHALL register the op, tag, operand magnitudes (two's-complement absolute value for signed ops), quotient sign (sign(dividend) XOR sign(divisor)), remainder sign (sign(dividend)), and the div-by-zero and overflow flags.
REQ-015 Iteration stages SHALL each perform BITS_PER_STAGE non-restoring steps on a DATA_WIDTH+1-bit partial remainder: shift left, add the divisor if the remainder is negative else subtract it, and set the quotient bit to the inverted remainder sign.
REQ-016 The final stage SHALL restore a negative remainder by adding the divisor, apply sign correction (negate the quotient if the quotient sign is set, negate the remainder if the remainder sign is set), select quotient or remainder by op[1], and register the result.
REQ-017 When divisor==0, result SHALL be all-ones for DIV/DIVU and the original dividend for REM/REMU.
REQ-018 For signed overflow (dividend = most-negative value, divisor = -1), result SHALL be the most-negative value for DIV and 0 for REM.
REQ-019 The special-case results of REQ-017/018 SHALL appear with the same LAT latency as normal ops, preserving order.
REQ-020 While stall=1, all stage registers including valids SHALL hold, in_valid SHALL be ignored, and out_valid/result/out_tag SHALL hold.
REQ-021 out_valid SHALL be asserted for exactly one non-stalled cycle per accepted op; result and out_tag SHALL be 0 when out_valid=0.
REQ-022 Ops SHALL complete strictly in issue order, and tags SHALL never be reordered or duplicated.

Reset
REQ-023 rst_n low SHALL asynchronously clear all stage valids and datapath registers; out_valid=0, result=0, out_tag=0, busy=0.
REQ-024 A reset asserted mid-operation SHALL discard all in-flight ops with no out_valid for them after release.
REQ-025 The first op SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-026 With macro DIV_FLUSH_EN defined, port flush SHALL exist; flush=1 clears all stage valids at the next edge (flush overrides stall), and an in_valid in the same cycle is dropped.
REQ-027 Without DIV_FLUSH_EN, the flush port SHALL be absent and valids SHALL clear only via reset.

Verification
REQ-028 DIVU 100/7, tag 3 -> after LAT=34 edges (W=32, BPS=1), out_valid=1, result=14, out_tag=3; REMU 100/7 -> result=2.
REQ-029 DIV -7/2 -> result=0xFFFFFFFD (-3); REM -7/2 -> result=0xFFFFFFFF (-1); REM 7/-2 -> result=1.
REQ-030 DIV 5/0 -> result=0xFFFFFFFF; REMU 5/0 -> result=5; DIV 0x80000000/0xFFFFFFFF -> result=0x80000000; REM of the same -> result=0.
REQ-031 Back-to-back random ops with tags 0..31 on consecutive cycles and random stall bursts -> results match the reference model in order, one out_valid per op, held during stall.
REQ-032 rst_n pulsed low with 10 ops in flight -> busy=0 immediately, no out_valid for them afterwards; a new op completes at LAT.
REQ-033 With DIV_FLUSH_EN: flush with stall=1 and ops in flight -> busy=0 next cycle; repeat REQ-028 with BITS_PER_STAGE=2 -> LAT=18.
